// File: rtl/dbg_trace_uart_if.sv
// Debug-trace port bundle: core debug outputs in, UART pin and status out.
// master = core/board side, slave = the trace serializer.
interface dbg_trace_uart_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          i_dbg_instruction_retired;
  logic [15:0]   i_dbg_pc;
  logic [7:0]    i_dbg_A;
  logic [3:0]    i_dbg_F;
  logic          i_dbg_halted;
  logic          o_tx;
  logic          o_busy;
  logic [LW-1:0] o_fifo_level;
  logic [7:0]    o_overflow_cnt;

  modport master (
    output i_dbg_instruction_retired, i_dbg_pc, i_dbg_A, i_dbg_F, i_dbg_halted,
    input  o_tx, o_busy, o_fifo_level, o_overflow_cnt
  );

  modport slave (
    input  i_dbg_instruction_retired, i_dbg_pc, i_dbg_A, i_dbg_F, i_dbg_halted,
    output o_tx, o_busy, o_fifo_level, o_overflow_cnt
  );
endinterface

// File: rtl/dbg_trace_uart.sv
// Debug trace serializer: snapshot FIFO feeding 5-byte 8N1 UART frames.
// Optional halt-marker frames are enabled by defining DBG_TRACE_HALT_MARKER_EN.
module dbg_trace_uart #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  dbg_trace_uart_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Entry layout: {halt_flag, pc[15:0], A[7:0], F[3:0]}
  function automatic logic [39:0] build_frame(input logic [28:0] e);
    build_frame = {(e[28] ? 8'h7F : 8'h7E), e[27:12], e[11:4], 4'h0, e[3:0]};
  endfunction

  logic [28:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [7:0]    r_ovf;

  state_t        r_state, w_state_nx;
  logic [BW-1:0] r_baud, w_baud_nx;
  logic [2:0]    r_bit, w_bit_nx;
  logic [2:0]    r_byte, w_byte_nx;
  logic [39:0]   r_frame, w_frame_nx;
  logic          r_tx, w_tx_nx;
  logic          r_busy, w_busy_nx;

  logic          w_halt_rise, w_push_req, w_push, w_drop, w_pop;
  logic          w_full, w_nonempty, w_bit_done;
  logic [28:0]   w_entry, w_head;
  logic [7:0]    w_cur_byte;

`ifdef DBG_TRACE_HALT_MARKER_EN
  logic r_halted_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_halted_d <= 1'b0;
    else       r_halted_d <= bus.i_dbg_halted;
  end

  assign w_halt_rise = bus.i_dbg_halted & ~r_halted_d;
`else
  logic w_unused_halted;
  assign w_unused_halted = bus.i_dbg_halted;
  assign w_halt_rise     = 1'b0;
`endif

  assign w_push_req = bus.i_dbg_instruction_retired | w_halt_rise;
  assign w_entry    = {w_halt_rise, bus.i_dbg_pc, bus.i_dbg_A, bus.i_dbg_F};
  assign w_full     = (r_level == LEVEL_FULL);
  assign w_nonempty = (r_level != {LW{1'b0}});
  // A full FIFO still accepts a push when the transmitter pops on the same edge.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_bit_done = (r_baud == BAUD_LAST);
  assign w_cur_byte = r_frame[39:32];

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {LW{1'b0}};
      r_ovf    <= 8'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (w_pop && !w_push) r_level <= r_level - LW'(1);
      if (w_drop && (r_ovf != 8'hFF)) r_ovf <= r_ovf + 8'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_baud  <= {BW{1'b0}};
      r_bit   <= 3'd0;
      r_byte  <= 3'd0;
      r_frame <= 40'd0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_baud  <= w_baud_nx;
      r_bit   <= w_bit_nx;
      r_byte  <= w_byte_nx;
      r_frame <= w_frame_nx;
      r_tx    <= w_tx_nx;
      r_busy  <= w_busy_nx;
    end
  end

  // tx is registered from the next-state decision so the pin changes on the transition edge.
  always_comb begin
    w_state_nx = r_state;
    w_baud_nx  = r_baud + BW'(1);
    w_bit_nx   = r_bit;
    w_byte_nx  = r_byte;
    w_frame_nx = r_frame;
    w_tx_nx    = r_tx;
    w_busy_nx  = r_busy;
    w_pop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_nx = {BW{1'b0}};
        if (w_nonempty) begin
          w_pop      = 1'b1;
          w_frame_nx = build_frame(w_head);
          w_byte_nx  = 3'd0;
          w_state_nx = S_START;
          w_tx_nx    = 1'b0;
          w_busy_nx  = 1'b1;
        end else begin
          w_tx_nx    = 1'b1;
          w_busy_nx  = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_done) begin
          w_baud_nx  = {BW{1'b0}};
          w_bit_nx   = 3'd0;
          w_state_nx = S_DATA;
          w_tx_nx    = w_cur_byte[0];
        end else begin
          w_state_nx = S_START;
        end
      end
      S_DATA: begin
        if (w_bit_done) begin
          w_baud_nx = {BW{1'b0}};
          if (r_bit == 3'd7) begin
            w_state_nx = S_STOP;
            w_tx_nx    = 1'b1;
          end else begin
            w_bit_nx   = r_bit + 3'd1;
            w_tx_nx    = w_cur_byte[r_bit + 3'd1];
          end
        end else begin
          w_state_nx = S_DATA;
        end
      end
      S_STOP: begin
        if (w_bit_done) begin
          w_baud_nx = {BW{1'b0}};
          if (r_byte != 3'd4) begin
            w_byte_nx  = r_byte + 3'd1;
            w_frame_nx = {r_frame[31:0], 8'h00};
            w_state_nx = S_START;
            w_tx_nx    = 1'b0;
          end else if (w_nonempty) begin
            w_pop      = 1'b1;
            w_frame_nx = build_frame(w_head);
            w_byte_nx  = 3'd0;
            w_state_nx = S_START;
            w_tx_nx    = 1'b0;
          end else begin
            w_state_nx = S_IDLE;
            w_tx_nx    = 1'b1;
            w_busy_nx  = 1'b0;
          end
        end else begin
          w_state_nx = S_STOP;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_baud_nx  = {BW{1'b0}};
        w_tx_nx    = 1'b1;
        w_busy_nx  = 1'b0;
      end
    endcase
  end

  assign bus.o_tx           = r_tx;
  assign bus.o_busy         = r_busy;
  assign bus.o_fifo_level   = r_level;
  assign bus.o_overflow_cnt = r_ovf;
endmodule

// File: tb/tb_dbg_trace_uart.sv
// Self-checking bench for dbg_trace_uart (CLKS_PER_BIT=4, FIFO_DEPTH=8).
module tb_dbg_trace_uart;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dbg_trace_uart_if #(.FIFO_DEPTH(DEPTH)) bus ();

  dbg_trace_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int fe_cnt = 0;
  logic [7:0] byte_q[$];
  int         start_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  a;
    logic [3:0]  f;
    logic [39:0] exp;
  } vec_t;
  vec_t vecs[3];

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // UART receiver: samples each bit mid-cell on the negative clock edge
  logic [7:0] mon_b;
  int         mon_sc;
  logic       mon_ok;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.o_tx == 1'b0) begin
        mon_sc = cyc;
        mon_ok = 1'b1;
        repeat (2) @(negedge clk);
        if (bus.o_tx !== 1'b0) mon_ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          mon_b[k] = bus.o_tx;
        end
        repeat (CPB) @(negedge clk);
        if (mon_ok) begin
          if (bus.o_tx !== 1'b1) fe_cnt++;
          byte_q.push_back(mon_b);
          start_q.push_back(mon_sc);
        end
      end
    end
  end

  task automatic clear_q();
    byte_q.delete();
    start_q.delete();
    fe_cnt = 0;
  endtask

  task automatic wait_done(input int bound, input int start, output int bc);
    bc = start;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.o_busy) bc++;
      else if (bc > 0) break;
    end
    repeat (8) @(negedge clk);
  endtask

  function automatic logic [39:0] got_frame(input int idx);
    logic [39:0] g;
    g = 40'd0;
    for (int k = 0; k < 5; k++) g = {g[31:0], byte_q[idx*5 + k]};
    return g;
  endfunction

  task automatic chk_gaps(input string name);
    int bad;
    bad = 0;
    for (int k = 1; k < start_q.size(); k++)
      if (start_q[k] - start_q[k-1] != 10*CPB) bad++;
    chk(name, bad, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    clear_q();
  endtask

  task automatic drive(input logic r, input logic [15:0] pc, input logic [7:0] a, input logic [3:0] f);
    bus.i_dbg_instruction_retired = r;
    bus.i_dbg_pc = pc;
    bus.i_dbg_A  = a;
    bus.i_dbg_F  = f;
  endtask

  int bc;
  int peak;
  int lows;
  logic [39:0] e40;

  initial begin
    vecs[0] = '{pc: 16'h0150, a: 8'h3C, f: 4'hB, exp: 40'h7E01503C0B};
    vecs[1] = '{pc: 16'hFFFF, a: 8'h00, f: 4'h0, exp: 40'h7EFFFF0000};
    vecs[2] = '{pc: 16'h1234, a: 8'hA5, f: 4'h5, exp: 40'h7E1234A505};

    drive(1'b0, 16'h0000, 8'h00, 4'h0);
    bus.i_dbg_halted = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", bus.o_tx, 1);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_level", bus.o_fifo_level, 0);
    chk("rst_ovf", bus.o_overflow_cnt, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single frames from the vector table
    for (int v = 0; v < 3; v++) begin
      clear_q();
      @(negedge clk);
      drive(1'b1, vecs[v].pc, vecs[v].a, vecs[v].f);
      @(negedge clk);
      drive(1'b0, 16'h0000, 8'h00, 4'h0);
      chk("push_level", bus.o_fifo_level, 1);
      chk("push_busy", bus.o_busy, 0);
      chk("push_tx", bus.o_tx, 1);
      @(negedge clk);
      chk("pop_level", bus.o_fifo_level, 0);
      chk("pop_busy", bus.o_busy, 1);
      chk("start_tx", bus.o_tx, 0);
      wait_done(1000, 1, bc);
      chk("busy_len", bc, 50*CPB);
      chk("idle_tx", bus.o_tx, 1);
      chk("idle_busy", bus.o_busy, 0);
      chk("byte_cnt", byte_q.size(), 5);
      if (byte_q.size() >= 5) chk("frame", got_frame(0), vecs[v].exp);
      chk("framing", fe_cnt, 0);
      chk_gaps("byte_gap");
    end

    // ten consecutive retires: one dropped, nine back-to-back frames
    clear_q();
    peak = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (int'(bus.o_fifo_level) > peak) peak = int'(bus.o_fifo_level);
      drive(1'b1, 16'h1000 + 16'(i), 8'(i), 4'(i));
    end
    @(negedge clk);
    if (int'(bus.o_fifo_level) > peak) peak = int'(bus.o_fifo_level);
    drive(1'b0, 16'h0000, 8'h00, 4'h0);
    chk("burst_peak", peak, 8);
    chk("burst_ovf", bus.o_overflow_cnt, 1);
    wait_done(3000, 0, bc);
    chk("burst_bytes", byte_q.size(), 45);
    if (byte_q.size() >= 45) begin
      for (int k = 0; k < 9; k++) begin
        e40 = {8'h7E, 8'h10, 8'(k), 8'(k), 4'h0, 4'(k)};
        chk("burst_frame", got_frame(k), e40);
      end
    end
    chk_gaps("burst_gap");
    chk("burst_framing", fe_cnt, 0);

    // 300 retires against a full FIFO: saturation, frames intact
    do_reset();
    for (int i = 0; i < 309; i++) begin
      @(negedge clk);
      if (i < 9) drive(1'b1, 16'h2000 + 16'(i), 8'h5A, 4'h3);
      else       drive(1'b1, 16'h3000 + 16'(i - 9), 8'h5A, 4'h3);
    end
    @(negedge clk);
    drive(1'b0, 16'h0000, 8'h00, 4'h0);
    chk("sat_ovf", bus.o_overflow_cnt, 255);
    chk("sat_level", bus.o_fifo_level, 8);
    wait_done(3000, 0, bc);
    chk("sat_bytes", byte_q.size(), 50);
    if (byte_q.size() >= 50) begin
      for (int k = 0; k < 9; k++) begin
        e40 = {8'h7E, 8'h20, 8'(k), 8'h5A, 8'h03};
        chk("sat_frame", got_frame(k), e40);
      end
      chk("sat_last", got_frame(9), 40'h7E30C05A03);
    end
    chk_gaps("sat_gap");
    chk("sat_framing", fe_cnt, 0);

    // reset during a data bit of byte 2 with three entries buffered
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 16'h4000 + 16'(i), 8'h77, 4'h1);
    end
    @(negedge clk);
    drive(1'b0, 16'h0000, 8'h00, 4'h0);
    chk("mid_level", bus.o_fifo_level, 3);
    repeat (90) @(negedge clk);
    chk("mid_busy", bus.o_busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_tx", bus.o_tx, 1);
    chk("async_busy", bus.o_busy, 0);
    chk("async_level", bus.o_fifo_level, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.o_tx !== 1'b1) lows++;
    end
    chk("post_rst_tx_lows", lows, 0);
    chk("post_rst_busy", bus.o_busy, 0);
    chk("post_rst_level", bus.o_fifo_level, 0);
    clear_q();
    @(negedge clk);
    drive(1'b1, 16'h4ABC, 8'h12, 4'hF);
    @(negedge clk);
    drive(1'b0, 16'h0000, 8'h00, 4'h0);
    wait_done(1000, 0, bc);
    chk("post_rst_bytes", byte_q.size(), 5);
    if (byte_q.size() >= 5) chk("post_rst_frame", got_frame(0), 40'h7E4ABC120F);

`ifdef DBG_TRACE_HALT_MARKER_EN
    clear_q();
    @(negedge clk);
    drive(1'b0, 16'h0200, 8'h11, 4'h9);
    bus.i_dbg_halted = 1'b1;
    @(negedge clk);
    drive(1'b0, 16'h0000, 8'h00, 4'h0);
    wait_done(1000, 0, bc);
    repeat (1000) @(negedge clk);
    chk("halt_bytes", byte_q.size(), 5);
    if (byte_q.size() >= 5) chk("halt_frame", got_frame(0), 40'h7F02001109);
    bus.i_dbg_halted = 1'b0;
    repeat (5) @(negedge clk);
    clear_q();
    drive(1'b1, 16'h0300, 8'h22, 4'h6);
    bus.i_dbg_halted = 1'b1;
    @(negedge clk);
    drive(1'b0, 16'h0000, 8'h00, 4'h0);
    wait_done(1000, 0, bc);
    repeat (300) @(negedge clk);
    chk("halt_ret_bytes", byte_q.size(), 5);
    if (byte_q.size() >= 5) chk("halt_ret_frame", got_frame(0), 40'h7F03002206);
    bus.i_dbg_halted = 1'b0;
`else
    clear_q();
    @(negedge clk);
    drive(1'b0, 16'h0200, 8'h11, 4'h9);
    bus.i_dbg_halted = 1'b1;
    repeat (300) @(negedge clk);
    chk("nohalt_bytes", byte_q.size(), 0);
    chk("nohalt_busy", bus.o_busy, 0);
    chk("nohalt_level", bus.o_fifo_level, 0);
    bus.i_dbg_halted = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dbg_trace_uart.md
# dbg_trace_uart

Debug trace serializer driven by the CPU core's debug outputs. It captures a snapshot on every retired instruction: PC, A, F and a halt flag. Snapshots are buffered in a small FIFO and shipped out as fixed 5-byte frames on a UART TX pin. This lets the board-level wrapper log execution to a host instead of showing only PC[7:0], A and C on LEDs and header pins. It runs in the same clock domain as the core and sits between the core's debug port and a spare header pin.

## Interface
- `CLKS_PER_BIT`, 104: clock cycles per UART bit; must be ≥ 2.
- `FIFO_DEPTH`, 8: number of snapshot entries; power of two, ≥ 2.
- `clk`  in  1  core clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `dbg_instruction_retired`  in  1  one-cycle pulse per retired instruction.
- `dbg_pc`  in  16  PC of the retired instruction.
- `dbg_A`  in  8  accumulator.
- `dbg_F`  in  4  flags (Z N H C).
- `dbg_halted`  in  1  core halted level.
- `tx`  out  1  UART 8N1 serial out; idles high.
- `busy`  out  1  high while a frame is in flight.
- `fifo_level`  out  log2(FIFO_DEPTH)+1  entries currently buffered.
- `overflow_cnt`  out  8  dropped snapshots, saturating.

## Operation
- Reset values:
  - `tx`=1, `busy`=0, `fifo_level`=0, `overflow_cnt`=0.
  - FSM in IDLE, FIFO pointers cleared.
- Capture: on a clk edge with `dbg_instruction_retired`=1, push the entry {halt_flag=0, dbg_pc, dbg_A, dbg_F}.
- Full FIFO: a push is dropped and `overflow_cnt` increments, saturating at 255. Exception: if a pop happens on the same edge, the push is accepted and the level is unchanged.
- Frame layout, in byte order:
  - header: 0x7E normal, 0x7F when halt_flag=1
  - PC[15:8]
  - PC[7:0]
  - A
  - {4'h0, F}
- UART format: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts exactly `CLKS_PER_BIT` cycles.
- FSM states: IDLE, START, DATA, STOP. An internal byte index counts 0..4 and a bit index counts 0..7.
  - IDLE → START when the FIFO is non-empty. On this edge the head entry is popped into a 40-bit frame register, the byte index is set to 0 and `busy` goes to 1.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → STOP after 8 bits.
  - STOP, byte index < 4: go to START, byte index +1.
  - STOP, byte index = 4, FIFO non-empty: pop the next entry and go straight to START, with no idle gap.
  - STOP, byte index = 4, FIFO empty: go to IDLE, `busy` to 0.
- `rst` asserted mid-operation: all outputs and state return to reset values immediately. Any frame in flight is truncated and buffered entries are lost.

## Timing
- A push at edge N into an empty FIFO while IDLE:
  - the pop happens at edge N+1;
  - `tx` falls for the start bit at edge N+1;
  - `fifo_level` reads 1 only during cycle N..N+1.
- Frame length is 50·`CLKS_PER_BIT` cycles. With `CLKS_PER_BIT`=4, `busy` is high for exactly 200 cycles for a single frame.
- `fifo_level` updates on the same edge as the push or pop; a simultaneous push and pop leaves it unchanged.
- The baud counter restarts at every bit boundary; no drift accumulates across bytes.

## Configuration
- `DBG_TRACE_HALT_MARKER_EN` defined:
  - A rising edge of `dbg_halted` (registered 0→1) pushes an entry with halt_flag=1 and the current `dbg_pc`, `dbg_A`, `dbg_F`.
  - If it coincides with `dbg_instruction_retired`, a single entry is pushed with halt_flag=1.
  - Holding `dbg_halted` high produces no further marker frames.
- Not defined: `dbg_halted` is ignored, halt_flag is always 0 and header 0x7F is never sent.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=8.
- Single retire, pc=0x0150, A=0x3C, F=0xB → `tx` bytes 7E 01 50 3C 0B with correct 8N1 framing; `busy` high 200 cycles, then `tx`=1 and `busy`=0.
- Retire pulses on 10 consecutive edges from idle → `fifo_level` peaks at 8; `overflow_cnt`=1; 9 frames sent back-to-back with no idle bits; PCs in push order, minus the 10th.
- 300 retires while the FIFO is full and the transmitter is mid-frame → `overflow_cnt`=255 (saturated); no corruption of the frame in flight.
- With the macro defined, `dbg_halted` rises while retire=0 at pc=0x0200 → one frame 7F 02 00 A {0,F}; `dbg_halted` held high for 1000 cycles → no extra frame. Without the macro → no frame.
- With the macro defined, retire and the `dbg_halted` rising edge on the same edge → exactly one frame, header 0x7F.
- `rst` pulsed during a data bit of byte 2, with 3 entries buffered → `tx`=1, `busy`=0, `fifo_level`=0 asynchronously. After release, `tx` stays 1 until a new retire pulse.
